// File: rtl/msd_adc_pkg.sv
// Shared types and constants for the MSD ADC serial readout block.
package msd_adc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        WRITE
    } state_t;

    localparam int MinClkDiv    = 2;
    localparam int DefTotalAdcs = 10;
    localparam int DefAdcBits   = 16;

    // SClk period may not be shorter than one low and one high clk cycle.
    function automatic logic [15:0] clamp_div(input logic [15:0] div);
        return (div < 16'(MinClkDiv)) ? 16'(MinClkDiv) : div;
    endfunction

    // An unusable high time (zero or not shorter than the period) falls back to 50%.
    function automatic logic [15:0] clamp_duty(input logic [15:0] duty, input logic [15:0] div);
        return (duty == 16'd0 || duty >= div) ? (div >> 1) : duty;
    endfunction

endpackage

// File: rtl/msd_adc_sclk_gen.sv
// SClk period generator: counts clk cycles within one SClk period using the
// latched div/duty and provides the SClk level plus rise / period-end ticks.
module msd_adc_sclk_gen
    import msd_adc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        active,
    input  logic        shifting,
    input  logic [15:0] div,
    input  logic [15:0] duty,
    output logic        sclk,
    output logic        rise,
    output logic        period_end
);

    logic [15:0] cnt;
    logic [15:0] low_len;

    assign low_len = div - duty;

    // Position inside the current period; restarts at every period end and while inactive.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (!active || period_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end

    // SClk only toggles while shifting; each bit period is low first, then high.
    assign period_end = active && (cnt == div - 16'd1);
    assign sclk       = !shifting || (cnt >= low_len);
    assign rise       = shifting && (cnt == low_len);

endmodule

// File: rtl/msd_adc_reader.sv
// MSD ADC bank serial reader: drives shared SClk/CsN, deserializes TotalAdcs
// SData lines MSB first and writes one word per ADC with a shared strobe.
// Build option: MSD_ADC_TEST_PATTERN_EN replaces the sampled data with
// {adc index, conversion counter} while keeping the serial timing unchanged.
module msd_adc_reader
    import msd_adc_pkg::*;
#(
    parameter int TotalAdcs = DefTotalAdcs,
    parameter int AdcBits   = DefAdcBits
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                en,
    input  logic                                start,
    input  logic [15:0]                         adcClkDiv,
    input  logic [15:0]                         adcClkDuty,
    output logic                                SClk,
    output logic                                CsN,
    input  logic [TotalAdcs-1:0]                SData,
    output logic [TotalAdcs-1:0][AdcBits-1:0]   fifoData,
    output logic                                fifoWr,
    input  logic [TotalAdcs-1:0]                fifoFull,
    output logic                                busy,
    output logic                                compl,
    output logic                                error
);

    localparam int BitW = $clog2(AdcBits);

    state_t                              state;
    state_t                              state_nxt;
    logic [15:0]                         div_q;
    logic [15:0]                         duty_q;
    logic [BitW-1:0]                     bit_cnt;
    logic                                last_bit;
    logic                                accept;
    logic                                any_full;
    logic                                active;
    logic                                shifting;
    logic                                sclk;
    logic                                rise;
    logic                                period_end;
    logic [TotalAdcs-1:0][AdcBits-1:0]   wr_words;
    logic [TotalAdcs-1:0][AdcBits-1:0]   data_q;

    assign accept   = (state == IDLE) && start && en;
    assign any_full = |fifoFull;
    assign last_bit = (bit_cnt == BitW'(AdcBits - 1));

    msd_adc_sclk_gen u_sclk_gen (
        .clk        (clk),
        .rst        (rst),
        .active     (active),
        .shifting   (shifting),
        .div        (div_q),
        .duty       (duty_q),
        .sclk       (sclk),
        .rise       (rise),
        .period_end (period_end)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; dropping en abandons any conversion immediately.
    always_comb begin
        state_nxt = state;
        if (state != IDLE && !en) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (start && en)            state_nxt = SETUP;
                SETUP:   if (period_end)             state_nxt = SHIFT;
                SHIFT:   if (period_end && last_bit) state_nxt = HOLD;
                HOLD:    if (period_end)             state_nxt = WRITE;
                WRITE:                               state_nxt = IDLE;
                default:                             state_nxt = IDLE;
            endcase
        end
    end

    // Output decode. CsN stays low through HOLD so the ADCs see a full
    // CS hold time after the last SClk rise; it releases in WRITE.
    always_comb begin
        active   = (state == SETUP) || (state == SHIFT) || (state == HOLD);
        shifting = (state == SHIFT);
        SClk     = sclk;
        CsN      = !active;
        busy     = (state != IDLE);
        compl    = (state == WRITE) && en;
        fifoWr   = (state == WRITE) && en && !any_full;
    end

    // Timing configuration is frozen for the whole conversion at accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            div_q  <= clamp_div(adcClkDiv);
            duty_q <= clamp_duty(adcClkDuty, clamp_div(adcClkDiv));
        end
    end

    // Bit counter: one increment per completed SHIFT period.
    always_ff @(posedge clk) begin
        if (!rst) begin
            bit_cnt <= '0;
        end else if (state != SHIFT) begin
            bit_cnt <= '0;
        end else if (period_end) begin
            bit_cnt <= bit_cnt + BitW'(1);
        end
    end

    // Sticky drop flag: set when a write is refused, cleared by the next accepted start.
    always_ff @(posedge clk) begin
        if (!rst) begin
            error <= 1'b0;
        end else if (accept) begin
            error <= 1'b0;
        end else if (compl && any_full) begin
            error <= 1'b0 | 1'b1;
        end
    end

    // Last written words, presented between writes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            data_q <= '0;
        end else if (fifoWr) begin
            data_q <= wr_words;
        end
    end

    assign fifoData = fifoWr ? wr_words : data_q;

`ifdef MSD_ADC_TEST_PATTERN_EN
    logic [AdcBits-5:0] conv_cnt;

    // Conversion counter advances on every finished conversion, written or dropped.
    always_ff @(posedge clk) begin
        if (!rst) begin
            conv_cnt <= '0;
        end else if (compl) begin
            conv_cnt <= conv_cnt + 1'b1;
        end
    end

    // Pattern word: ADC index in the top nibble, conversion count below.
    always_comb begin
        wr_words = '0;
        for (int i = 0; i < TotalAdcs; i++) begin
            wr_words[i] = {4'(i), conv_cnt};
        end
    end
`else
    logic [TotalAdcs-1:0][AdcBits-1:0] shreg;

    // Per-ADC deserializers, sampled on the clk cycle where SClk rises.
    always_ff @(posedge clk) begin
        if (rise) begin
            for (int i = 0; i < TotalAdcs; i++) begin
                shreg[i] <= {shreg[i][AdcBits-2:0], SData[i]};
            end
        end
    end

    assign wr_words = shreg;
`endif

endmodule

// File: tb/tb_msd_adc_reader.sv
// Self-checking bench for msd_adc_reader with a bit-serial ADC model and a
// conversion-level reference (latency, words, flags) computed from the rules.
module tb_msd_adc_reader;

    localparam int NA = 10;
    localparam int NB = 16;

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic                    en = 1'b0;
    logic                    start = 1'b0;
    logic [15:0]             adcClkDiv = 16'd4;
    logic [15:0]             adcClkDuty = 16'd2;
    logic                    SClk, CsN, fifoWr, busy, compl, error;
    logic [NA-1:0]           SData = '0;
    logic [NA-1:0]           fifoFull = '0;
    logic [NA-1:0][NB-1:0]   fifoData;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    logic [NB-1:0]           adc_word [NA];
    logic [NA-1:0][NB-1:0]   wr_data;
    logic [NA-1:0][NB-1:0]   last_written = '0;
    int  wr_cnt = 0, wr_cyc = -1, compl_cnt = 0, rise_cnt = 0, csn_lo = 0;
    int  lo_run = 0, lo_last = 0, nrise = 0, exp_conv = 0;
    logic sclk_prev = 1'b1;
    logic mon_rs, mon_fl;

    msd_adc_reader dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .start      (start),
        .adcClkDiv  (adcClkDiv),
        .adcClkDuty (adcClkDuty),
        .SClk       (SClk),
        .CsN        (CsN),
        .SData      (SData),
        .fifoData   (fifoData),
        .fifoWr     (fifoWr),
        .fifoFull   (fifoFull),
        .busy       (busy),
        .compl      (compl),
        .error      (error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor plus ADC model: ADCs present the next bit after each SClk fall, MSB first.
    always @(negedge clk) begin
        mon_rs = SClk && !sclk_prev;
        mon_fl = !SClk && sclk_prev;
        if (fifoWr) begin
            wr_cnt++;
            if (wr_cyc < 0) wr_cyc = cyc;
            wr_data = fifoData;
        end
        if (compl) compl_cnt++;
        if (mon_rs) rise_cnt++;
        if (!CsN) csn_lo++;
        if (mon_fl) lo_run = 1;
        else if (!SClk) lo_run++;
        if (mon_rs) lo_last = lo_run;
        if (CsN) nrise = 0;
        else if (mon_rs) nrise++;
        if (CsN || mon_fl) begin
            for (int i = 0; i < NA; i++)
                SData[i] = (nrise < NB) ? adc_word[i][NB-1-nrise] : 1'b0;
        end
        sclk_prev = SClk;
    end

    function automatic int eff_div(input logic [15:0] d);
        return (d < 16'd2) ? 2 : int'(d);
    endfunction

    function automatic int eff_duty(input logic [15:0] du, input int dv);
        return (du == 16'd0 || int'(du) >= dv) ? dv / 2 : int'(du);
    endfunction

    function automatic logic [NA-1:0][NB-1:0] exp_words(input int conv);
        logic [NA-1:0][NB-1:0] r;
        for (int i = 0; i < NA; i++) begin
`ifdef MSD_ADC_TEST_PATTERN_EN
            r[i] = {4'(i), 12'(conv)};
`else
            r[i] = adc_word[i];
`endif
        end
        return r;
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        wr_cnt = 0; wr_cyc = -1; compl_cnt = 0; rise_cnt = 0; csn_lo = 0; lo_last = 0;
    endtask

    task automatic pulse_start(output int sc);
        sc = cyc;
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit to);
        to = 1'b1;
        for (int k = 0; k < budget; k++) begin
            if (!busy) begin
                to = 1'b0;
                break;
            end
            step(1);
        end
    endtask

    task automatic randomize_words();
        for (int i = 0; i < NA; i++) adc_word[i] = 16'($urandom);
    endtask

    task automatic test_reset();
        rst = 1'b0; en = 1'b0;
        step(3);
        n_cmp++; if (SClk !== 1'b1) begin n_bad++; $display("FAIL reset_sclk got %b want 1", SClk); end
        n_cmp++; if (CsN !== 1'b1) begin n_bad++; $display("FAIL reset_csn got %b want 1", CsN); end
        n_cmp++; if ({fifoWr, busy, compl, error} !== 4'b0000) begin n_bad++; $display("FAIL reset_flags got %b want 0000", {fifoWr, busy, compl, error}); end
        n_cmp++; if (fifoData !== '0) begin n_bad++; $display("FAIL reset_data got %h want 0", fifoData); end
        rst = 1'b1; en = 1'b1;
        exp_conv = 0; last_written = '0;
        step(2);
    endtask

    task automatic test_basic();
        int sc; bit to;
        logic [NA-1:0][NB-1:0] ew;
        adcClkDiv = 16'd4; adcClkDuty = 16'd2; fifoFull = '0;
        for (int i = 0; i < NA; i++) adc_word[i] = 16'h0000;
        adc_word[0] = 16'hA5C3; adc_word[9] = 16'h0001;
        step(2);
        ew = exp_words(exp_conv);
        clear_mon();
        pulse_start(sc);
        wait_idle(200, to);
        n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL basic_timeout busy still %b", busy); end
        n_cmp++; if (wr_cnt !== 1) begin n_bad++; $display("FAIL basic_wr_count got %0d want 1", wr_cnt); end
        n_cmp++; if (wr_cyc - sc !== 73) begin n_bad++; $display("FAIL basic_latency got %0d want 73", wr_cyc - sc); end
        n_cmp++; if (wr_data[0] !== ew[0]) begin n_bad++; $display("FAIL basic_adc0 got %h want %h", wr_data[0], ew[0]); end
        n_cmp++; if (wr_data[9] !== ew[9]) begin n_bad++; $display("FAIL basic_adc9 got %h want %h", wr_data[9], ew[9]); end
        n_cmp++; if (wr_data !== ew) begin n_bad++; $display("FAIL basic_all got %h want %h", wr_data, ew); end
        n_cmp++; if (csn_lo !== 72) begin n_bad++; $display("FAIL basic_csn_low got %0d want 72", csn_lo); end
        n_cmp++; if (rise_cnt !== 16) begin n_bad++; $display("FAIL basic_rises got %0d want 16", rise_cnt); end
        n_cmp++; if (compl_cnt !== 1) begin n_bad++; $display("FAIL basic_compl got %0d want 1", compl_cnt); end
        n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL basic_error got %b want 0", error); end
        n_cmp++; if (fifoData !== ew) begin n_bad++; $display("FAIL basic_hold got %h want %h", fifoData, ew); end
        exp_conv++; last_written = ew;
    endtask

    task automatic test_full_drop();
        int sc; bit to;
        logic [NA-1:0][NB-1:0] ew;
        randomize_words();
        fifoFull = '0; fifoFull[3] = 1'b1;
        step(2);
        clear_mon();
        pulse_start(sc);
        wait_idle(200, to);
        n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL drop_timeout busy still %b", busy); end
        n_cmp++; if (wr_cnt !== 0) begin n_bad++; $display("FAIL drop_wr_count got %0d want 0", wr_cnt); end
        n_cmp++; if (compl_cnt !== 1) begin n_bad++; $display("FAIL drop_compl got %0d want 1", compl_cnt); end
        n_cmp++; if (error !== 1'b1) begin n_bad++; $display("FAIL drop_error got %b want 1", error); end
        n_cmp++; if (fifoData !== last_written) begin n_bad++; $display("FAIL drop_hold got %h want %h", fifoData, last_written); end
        exp_conv++;
        fifoFull = '0;
        randomize_words();
        step(2);
        ew = exp_words(exp_conv);
        clear_mon();
        pulse_start(sc);
        n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL drop_error_clear got %b want 0", error); end
        wait_idle(200, to);
        n_cmp++; if (wr_cnt !== 1 || wr_data !== ew) begin n_bad++; $display("FAIL drop_recover got %0d/%h want 1/%h", wr_cnt, wr_data, ew); end
        exp_conv++; last_written = ew;
    endtask

    task automatic test_back_to_back();
        int sc, sc2; bit to;
        logic [NA-1:0][NB-1:0] ew;
        adcClkDiv = 16'd4; adcClkDuty = 16'd2;
        randomize_words();
        step(2);
        ew = exp_words(exp_conv);
        clear_mon();
        pulse_start(sc);
        step(9);
        pulse_start(sc2);
        wait_idle(200, to);
        n_cmp++; if (wr_cnt !== 1) begin n_bad++; $display("FAIL b2b_wr_count got %0d want 1", wr_cnt); end
        n_cmp++; if (wr_cyc - sc !== 73) begin n_bad++; $display("FAIL b2b_latency got %0d want 73", wr_cyc - sc); end
        n_cmp++; if (wr_data !== ew) begin n_bad++; $display("FAIL b2b_data got %h want %h", wr_data, ew); end
        exp_conv++; last_written = ew;
        clear_mon();
        step(100);
        n_cmp++; if (wr_cnt !== 0 || busy !== 1'b0) begin n_bad++; $display("FAIL b2b_idle got wr=%0d busy=%b want 0/0", wr_cnt, busy); end
    endtask

    task automatic test_abort();
        int sc; bit to;
        logic [NA-1:0][NB-1:0] ew;
        adcClkDiv = 16'd4; adcClkDuty = 16'd2;
        en = 1'b0;
        pulse_start(sc);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_start_en0 busy got %b want 0", busy); end
        en = 1'b1;
        randomize_words();
        step(2);
        clear_mon();
        pulse_start(sc);
        step(33);
        en = 1'b0;
        step(1);
        n_cmp++; if ({CsN, SClk, busy} !== 3'b110) begin n_bad++; $display("FAIL abort_outputs got CsN,SClk,busy=%b want 110", {CsN, SClk, busy}); end
        en = 1'b1;
        step(100);
        n_cmp++; if (wr_cnt !== 0 || compl_cnt !== 0) begin n_bad++; $display("FAIL abort_no_write got wr=%0d compl=%0d want 0/0", wr_cnt, compl_cnt); end
        randomize_words();
        step(2);
        ew = exp_words(exp_conv);
        clear_mon();
        pulse_start(sc);
        wait_idle(200, to);
        n_cmp++; if (wr_cnt !== 1 || wr_data !== ew || wr_cyc - sc !== 73) begin n_bad++; $display("FAIL abort_recover got %0d/%h/%0d want 1/%h/73", wr_cnt, wr_data, wr_cyc - sc, ew); end
        exp_conv++; last_written = ew;
    endtask

    task automatic test_clamp();
        int sc; bit to;
        adcClkDiv = 16'd1; adcClkDuty = 16'd0;
        randomize_words();
        step(2);
        clear_mon();
        pulse_start(sc);
        wait_idle(200, to);
        n_cmp++; if (wr_cyc - sc !== 37) begin n_bad++; $display("FAIL clamp_div_latency got %0d want 37", wr_cyc - sc); end
        n_cmp++; if (lo_last !== 1) begin n_bad++; $display("FAIL clamp_div_low got %0d want 1", lo_last); end
        exp_conv++; last_written = exp_words(exp_conv - 1);
        n_cmp++; if (wr_data !== last_written) begin n_bad++; $display("FAIL clamp_div_data got %h want %h", wr_data, last_written); end
        adcClkDiv = 16'd4; adcClkDuty = 16'd5;
        step(2);
        clear_mon();
        pulse_start(sc);
        wait_idle(200, to);
        n_cmp++; if (lo_last !== 2 || wr_cyc - sc !== 73) begin n_bad++; $display("FAIL clamp_duty got low=%0d lat=%0d want 2/73", lo_last, wr_cyc - sc); end
        exp_conv++; last_written = exp_words(exp_conv - 1);
    endtask

    task automatic test_random();
        int sc, dv, dt, lat; bit to; bit drop;
        logic [NA-1:0][NB-1:0] ew;
        for (int it = 0; it < 8; it++) begin
            adcClkDiv  = 16'($urandom_range(0, 6));
            adcClkDuty = 16'($urandom_range(0, 8));
            randomize_words();
            drop = ($urandom_range(0, 2) == 0);
            fifoFull = drop ? NA'($urandom_range(1, (1 << NA) - 1)) : '0;
            dv  = eff_div(adcClkDiv);
            dt  = eff_duty(adcClkDuty, dv);
            lat = 1 + dv * (NB + 2);
            step(2);
            ew = exp_words(exp_conv);
            clear_mon();
            pulse_start(sc);
            wait_idle(400, to);
            n_cmp++; if (to !== 1'b0 || compl_cnt !== 1) begin n_bad++; $display("FAIL rnd%0d_done got to=%b compl=%0d want 0/1", it, to, compl_cnt); end
            n_cmp++; if (rise_cnt !== NB || lo_last !== dv - dt) begin n_bad++; $display("FAIL rnd%0d_sclk got rises=%0d low=%0d want %0d/%0d", it, rise_cnt, lo_last, NB, dv - dt); end
            if (drop) begin
                n_cmp++; if (wr_cnt !== 0 || error !== 1'b1 || fifoData !== last_written) begin n_bad++; $display("FAIL rnd%0d_drop got wr=%0d err=%b data=%h want 0/1/%h", it, wr_cnt, error, fifoData, last_written); end
            end else begin
                n_cmp++; if (wr_cnt !== 1 || error !== 1'b0 || wr_cyc - sc !== lat) begin n_bad++; $display("FAIL rnd%0d_write got wr=%0d err=%b lat=%0d want 1/0/%0d", it, wr_cnt, error, wr_cyc - sc, lat); end
                n_cmp++; if (wr_data !== ew) begin n_bad++; $display("FAIL rnd%0d_data got %h want %h", it, wr_data, ew); end
                last_written = ew;
            end
            exp_conv++;
        end
        fifoFull = '0;
    endtask

    task automatic test_rst_mid();
        int sc;
        adcClkDiv = 16'd4; adcClkDuty = 16'd2;
        step(2);
        clear_mon();
        pulse_start(sc);
        step(20);
        rst = 1'b0;
        step(1);
        n_cmp++; if ({SClk, CsN, busy} !== 3'b110) begin n_bad++; $display("FAIL rstmid_outputs got SClk,CsN,busy=%b want 110", {SClk, CsN, busy}); end
        n_cmp++; if (fifoData !== '0 || error !== 1'b0) begin n_bad++; $display("FAIL rstmid_data got %h/%b want 0/0", fifoData, error); end
        rst = 1'b1;
        exp_conv = 0; last_written = '0;
        step(100);
        n_cmp++; if (wr_cnt !== 0) begin n_bad++; $display("FAIL rstmid_no_write got %0d want 0", wr_cnt); end
    endtask

`ifdef MSD_ADC_TEST_PATTERN_EN
    task automatic test_pattern();
        int sc; bit to;
        for (int k = 0; k < 3; k++) begin
            randomize_words();
            step(2);
            clear_mon();
            pulse_start(sc);
            wait_idle(200, to);
            n_cmp++; if (wr_data[2] !== 16'h2000 + 16'(k)) begin n_bad++; $display("FAIL pattern%0d_adc2 got %h want %h", k, wr_data[2], 16'h2000 + 16'(k)); end
            exp_conv++;
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < NA; i++) adc_word[i] = '0;
        test_reset();
        test_basic();
        test_full_drop();
        test_back_to_back();
        test_abort();
        test_clamp();
        test_random();
        test_rst_mid();
`ifdef MSD_ADC_TEST_PATTERN_EN
        test_pattern();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
